// File: rtl/game_fsm_ctrl.sv
// Game-state controller: multi-life IDLE/PLAY/PAUSE/DYING/OVER FSM with pause toggle,
// respawn delay and apple-driven level counter. All outputs are registered.
module game_fsm_ctrl #(
    parameter int LIVES            = 3,
    parameter int LIFE_W           = 2,
    parameter int RESPAWN_TICKS    = 2,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int LEVEL_W          = 3,
    parameter int MAX_LEVEL        = 7
) (
    input  logic               clk_1s,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               is_crash,
    input  logic               is_suicide,
    input  logic               apple_eaten,
    output logic [2:0]         state,
    output logic               running,
    output logic               game_over,
    output logic [LIFE_W-1:0]  lives,
    output logic [LEVEL_W-1:0] level,
    output logic               life_lost,
    output logic               level_up
);

    localparam int CNT_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
    localparam int RSP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             r_state;
    logic [LIFE_W-1:0]  r_lives;
    logic [LEVEL_W-1:0] r_level;
    logic [CNT_W-1:0]   r_apple_cnt;
    logic [RSP_W-1:0]   r_respawn_cnt;
    logic               r_life_lost;
    logic               r_level_up;
    logic               r_running;
    logic               r_game_over;
    logic               r_start_q;
    logic               r_pause_q;

    state_t             w_state_nxt;
    logic [LIFE_W-1:0]  w_lives_nxt;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [CNT_W-1:0]   w_apple_nxt;
    logic [RSP_W-1:0]   w_respawn_nxt;
    logic               w_life_lost_nxt;
    logic               w_level_up_nxt;
    logic               w_running_nxt;
    logic               w_game_over_nxt;
    logic               w_start_rise;
    logic               w_pause_rise;
    logic               w_hit;

    assign w_start_rise = start_btn & ~r_start_q;
    assign w_pause_rise = pause_btn & ~r_pause_q;
    assign w_hit        = is_crash | is_suicide;

    always_ff @(posedge clk_1s or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_lives       <= LIFE_W'(LIVES);
            r_level       <= LEVEL_W'(1);
            r_apple_cnt   <= '0;
            r_respawn_cnt <= '0;
            r_life_lost   <= 1'b0;
            r_level_up    <= 1'b0;
            r_running     <= 1'b0;
            r_game_over   <= 1'b0;
            r_start_q     <= 1'b0;
            r_pause_q     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lives       <= w_lives_nxt;
            r_level       <= w_level_nxt;
            r_apple_cnt   <= w_apple_nxt;
            r_respawn_cnt <= w_respawn_nxt;
            r_life_lost   <= w_life_lost_nxt;
            r_level_up    <= w_level_up_nxt;
            r_running     <= w_running_nxt;
            r_game_over   <= w_game_over_nxt;
            r_start_q     <= start_btn;
            r_pause_q     <= pause_btn;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_level_nxt     = r_level;
        w_apple_nxt     = r_apple_cnt;
        w_respawn_nxt   = r_respawn_cnt;
        w_life_lost_nxt = 1'b0;
        w_level_up_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                // A hit wins the tick outright; pause and apple are dropped with it.
                if (w_hit) begin
                    w_lives_nxt     = r_lives - LIFE_W'(1);
                    w_life_lost_nxt = 1'b1;
                    if (r_lives == LIFE_W'(1)) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt   = ST_DYING;
                        w_respawn_nxt = RSP_W'(RESPAWN_TICKS - 1);
                    end
                end else begin
                    if (w_pause_rise) w_state_nxt = ST_PAUSE;
                    if (apple_eaten) begin
                        if (r_apple_cnt == CNT_W'(APPLES_PER_LEVEL - 1)) begin
                            w_apple_nxt = '0;
                            if (r_level < LEVEL_W'(MAX_LEVEL)) begin
                                w_level_nxt    = r_level + LEVEL_W'(1);
                                w_level_up_nxt = 1'b1;
                            end
                        end else begin
                            w_apple_nxt = r_apple_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause_rise) w_state_nxt = ST_PLAY;
            end
            ST_DYING: begin
                if (r_respawn_cnt == '0) w_state_nxt = ST_PLAY;
                else                     w_respawn_nxt = r_respawn_cnt - RSP_W'(1);
            end
            ST_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LIFE_W'(LIVES);
                    w_level_nxt = LEVEL_W'(1);
                    w_apple_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_running_nxt   = (w_state_nxt == ST_PLAY);
        w_game_over_nxt = (w_state_nxt == ST_OVER);
    end

    assign state     = r_state;
    assign running   = r_running;
    assign game_over = r_game_over;
    assign lives     = r_lives;
    assign level     = r_level;
    assign life_lost = r_life_lost;
    assign level_up  = r_level_up;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Bench for game_fsm_ctrl: table of directed ticks plus hand sequences for
// mid-game reset and the apple/level saturation run.
module tb_game_fsm_ctrl;

    logic       clk_1s = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       is_crash = 1'b0;
    logic       is_suicide = 1'b0;
    logic       apple_eaten = 1'b0;
    logic [2:0] state;
    logic       running;
    logic       game_over;
    logic [1:0] lives;
    logic [2:0] level;
    logic       life_lost;
    logic       level_up;

    int n_cmp = 0;
    int n_err = 0;

    game_fsm_ctrl dut (
        .clk_1s     (clk_1s),
        .rst        (rst),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .is_crash   (is_crash),
        .is_suicide (is_suicide),
        .apple_eaten(apple_eaten),
        .state      (state),
        .running    (running),
        .game_over  (game_over),
        .lives      (lives),
        .level      (level),
        .life_lost  (life_lost),
        .level_up   (level_up)
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct {
        logic       st, pa, cr, su, ap;
        logic [2:0] e_state;
        logic [1:0] e_lives;
        logic [2:0] e_level;
        logic       e_ll, e_lu;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(logic st, logic pa, logic cr, logic su, logic ap,
                                logic [2:0] es, logic [1:0] el, logic [2:0] ev,
                                logic ell, logic elu);
        vec_t v;
        v.st = st; v.pa = pa; v.cr = cr; v.su = su; v.ap = ap;
        v.e_state = es; v.e_lives = el; v.e_level = ev; v.e_ll = ell; v.e_lu = elu;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] es, input logic [1:0] el,
                             input logic [2:0] ev, input logic ell, input logic elu);
        check("state", idx, int'(state), int'(es));
        check("lives", idx, int'(lives), int'(el));
        check("level", idx, int'(level), int'(ev));
        check("life_lost", idx, int'(life_lost), int'(ell));
        check("level_up", idx, int'(level_up), int'(elu));
        check("running", idx, int'(running), int'(es == 3'd1));
        check("game_over", idx, int'(game_over), int'(es == 3'd4));
    endtask

    // Inputs change on the falling edge, DUT samples on the rising edge,
    // outputs are checked on the following falling edge.
    task automatic step(input logic st, input logic pa, input logic cr,
                        input logic su, input logic ap);
        start_btn = st; pause_btn = pa; is_crash = cr; is_suicide = su; apple_eaten = ap;
        @(posedge clk_1s);
        @(negedge clk_1s);
    endtask

    initial begin
        int mcnt;
        int mlev;
        logic mlu;

        //              st pa cr su ap  state lives level ll lu
        vecs[0]  = mk(1, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 3'd3, 2'd2, 3'd1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 3'd3, 2'd2, 3'd1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 3'd1, 2'd2, 3'd1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 3'd3, 2'd1, 3'd1, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 3'd3, 2'd1, 3'd1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 3'd1, 2'd1, 3'd1, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 0, 3'd4, 2'd0, 3'd1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 3'd4, 2'd0, 3'd1, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 0, 3'd2, 2'd3, 3'd1, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 0, 3'd2, 2'd3, 3'd1, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 1, 3'd2, 2'd3, 3'd1, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 1, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[19] = mk(0, 1, 0, 0, 1, 3'd2, 2'd3, 3'd1, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 3'd2, 2'd3, 3'd1, 0, 0);
        vecs[21] = mk(0, 1, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 3'd1, 2'd3, 3'd1, 0, 0);
        vecs[23] = mk(0, 1, 0, 1, 1, 3'd3, 2'd2, 3'd1, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 3'd3, 2'd2, 3'd1, 0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 3'd1, 2'd2, 3'd1, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 1, 3'd1, 2'd2, 3'd1, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 1, 3'd1, 2'd2, 3'd1, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 3'd1, 2'd2, 3'd2, 0, 1);
        vecs[29] = mk(0, 0, 0, 0, 0, 3'd1, 2'd2, 3'd2, 0, 0);
        vecs[30] = mk(0, 0, 1, 0, 0, 3'd3, 2'd1, 3'd2, 1, 0);

        // Reset values while rst is held low
        repeat (2) @(negedge clk_1s);
        check_all(-1, 3'd0, 2'd3, 3'd1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk_1s);
        check_all(-2, 3'd0, 2'd3, 3'd1, 1'b0, 1'b0);

        for (int i = 0; i < 31; i++) begin
            step(vecs[i].st, vecs[i].pa, vecs[i].cr, vecs[i].su, vecs[i].ap);
            check_all(i, vecs[i].e_state, vecs[i].e_lives, vecs[i].e_level,
                      vecs[i].e_ll, vecs[i].e_lu);
        end

        // Asynchronous reset in the middle of DYING takes effect without a clock edge
        check("pre_rst_state", 100, int'(state), 3);
        start_btn = 0; pause_btn = 0; is_crash = 0; is_suicide = 0; apple_eaten = 0;
        rst = 1'b0;
        #1;
        check_all(101, 3'd0, 2'd3, 3'd1, 1'b0, 1'b0);
        @(negedge clk_1s);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        check_all(102, 3'd0, 2'd3, 3'd1, 1'b0, 1'b0);

        // Apple run to level saturation
        step(1, 0, 0, 0, 0);
        check_all(200, 3'd1, 2'd3, 3'd1, 1'b0, 1'b0);
        mcnt = 0;
        mlev = 1;
        for (int a = 1; a <= 35; a++) begin
            mlu = 1'b0;
            if (mcnt == 4) begin
                mcnt = 0;
                if (mlev < 7) begin
                    mlev++;
                    mlu = 1'b1;
                end
            end else begin
                mcnt++;
            end
            step(0, 0, 0, 0, 1);
            check("apple_level", 200 + a, int'(level), mlev);
            check("apple_level_up", 200 + a, int'(level_up), int'(mlu));
            check("apple_running", 200 + a, int'(running), 1);
        end
        check("final_level", 300, int'(level), 7);
        step(0, 0, 0, 0, 0);
        check_all(301, 3'd1, 2'd3, 3'd7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
